// File: rtl/median_denoise_pipe.sv
// Row-streaming 3x3 median denoise filter with a two-stage (window, median) pipeline.
// Optional impulse-threshold bypass enabled by defining MEDIAN_DENOISE_THRESH_EN.
module median_denoise_pipe #(
    parameter int BIT_WIDTH = 8,
    parameter int ROW_PIX   = 8,
    parameter int ROWS      = 8,
    parameter int THRESH    = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sof,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BIT_WIDTH*ROW_PIX-1:0]      pix_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BIT_WIDTH*(ROW_PIX-2)-1:0]  pix_out,
    output logic                              out_last
);

    localparam int ROW_W   = BIT_WIDTH * ROW_PIX;
    localparam int OUT_PIX = ROW_PIX - 2;
    localparam int OUT_W   = BIT_WIDTH * OUT_PIX;
    localparam int CNT_W   = $clog2(ROWS);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    typedef logic [BIT_WIDTH-1:0] pix_t;

    // Full 9-element min/max exchange sort; element 4 is the median.
    function automatic pix_t median9(input pix_t win [9]);
        pix_t v [9];
        pix_t lo;
        pix_t hi;
        v = win;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8 - i; k++) begin
                lo       = (v[k] < v[k+1]) ? v[k] : v[k+1];
                hi       = (v[k] < v[k+1]) ? v[k+1] : v[k];
                v[k]     = lo;
                v[k+1]   = hi;
            end
        end
        return v[4];
    endfunction

`ifdef MEDIAN_DENOISE_THRESH_EN
    localparam logic [BIT_WIDTH:0] THRESH_V = (BIT_WIDTH+1)'(THRESH);

    // Keep the centre pixel unless it deviates from the median by more than THRESH.
    function automatic pix_t thresh_sel(input pix_t center, input pix_t med);
        pix_t diff;
        diff = (center > med) ? (center - med) : (med - center);
        return ({1'b0, diff} > THRESH_V) ? med : center;
    endfunction
`endif

    logic                 in_ready_s;
    logic                 accept_s;
    logic                 emit_s;
    logic [CNT_W-1:0]     row_idx_s;
    logic [CNT_W-1:0]     row_cnt_r;
    logic [ROW_W-1:0]     line_a_r;
    logic [ROW_W-1:0]     line_b_r;
    logic [ROW_W-1:0]     win_top_r;
    logic [ROW_W-1:0]     win_mid_r;
    logic [ROW_W-1:0]     win_bot_r;
    logic                 win_valid_r;
    logic                 win_last_r;
    logic [OUT_W-1:0]     filt_s;
    logic [OUT_W-1:0]     pix_out_r;
    logic                 out_valid_r;
    logic                 out_last_r;

    assign in_ready_s = ~(out_valid_r & ~out_ready);
    assign accept_s   = in_valid & in_ready_s;
    assign emit_s     = accept_s & (row_idx_s >= CNT_W'(2));

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign pix_out    = pix_out_r;

    // Row index of the incoming row: sof restarts the frame at row 0.
    always_comb begin
        row_idx_s = row_cnt_r;
        if (sof) begin
            row_idx_s = '0;
        end else begin
            row_idx_s = row_cnt_r;
        end
    end

    // Row counter and the two line buffers advance only on an accepted row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_r <= '0;
            line_a_r  <= '0;
            line_b_r  <= '0;
        end else if (accept_s) begin
            row_cnt_r <= (row_idx_s == LAST_ROW) ? '0 : row_idx_s + 1'b1;
            line_a_r  <= line_b_r;
            line_b_r  <= pix_in;
        end else begin
            row_cnt_r <= row_cnt_r;
            line_a_r  <= line_a_r;
            line_b_r  <= line_b_r;
        end
    end

    // Window stage: capture rows r-2, r-1, r when the triggering row arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_top_r   <= '0;
            win_mid_r   <= '0;
            win_bot_r   <= '0;
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
        end else if (in_ready_s) begin
            win_valid_r <= emit_s;
            if (emit_s) begin
                win_top_r  <= line_a_r;
                win_mid_r  <= line_b_r;
                win_bot_r  <= pix_in;
                win_last_r <= (row_idx_s == LAST_ROW);
            end else begin
                win_top_r  <= win_top_r;
                win_mid_r  <= win_mid_r;
                win_bot_r  <= win_bot_r;
                win_last_r <= win_last_r;
            end
        end else begin
            win_valid_r <= win_valid_r;
            win_top_r   <= win_top_r;
            win_mid_r   <= win_mid_r;
            win_bot_r   <= win_bot_r;
            win_last_r  <= win_last_r;
        end
    end

    for (genvar j = 0; j < OUT_PIX; j++) begin : g_col
        pix_t win_s [9];

        // Gather the 3x3 neighbourhood for output column j (centre at index 4).
        always_comb begin
            for (int k = 0; k < 3; k++) begin
                win_s[k]     = win_top_r[(j+k)*BIT_WIDTH +: BIT_WIDTH];
                win_s[3 + k] = win_mid_r[(j+k)*BIT_WIDTH +: BIT_WIDTH];
                win_s[6 + k] = win_bot_r[(j+k)*BIT_WIDTH +: BIT_WIDTH];
            end
        end

`ifdef MEDIAN_DENOISE_THRESH_EN
        assign filt_s[j*BIT_WIDTH +: BIT_WIDTH] = thresh_sel(win_s[4], median9(win_s));
`else
        assign filt_s[j*BIT_WIDTH +: BIT_WIDTH] = median9(win_s);
`endif
    end

    // Median stage: register the filtered row; everything freezes while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out_r   <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (in_ready_s) begin
            out_valid_r <= win_valid_r;
            if (win_valid_r) begin
                pix_out_r  <= filt_s;
                out_last_r <= win_last_r;
            end else begin
                pix_out_r  <= pix_out_r;
                out_last_r <= 1'b0;
            end
        end else begin
            pix_out_r   <= pix_out_r;
            out_valid_r <= out_valid_r;
            out_last_r  <= out_last_r;
        end
    end

endmodule

// File: tb/tb_median_denoise_pipe.sv
// Self-checking bench for median_denoise_pipe: frame-level reference model plus directed frames.
module tb_median_denoise_pipe;

    localparam int BW = 8;
    localparam int RP = 8;
    localparam int NR = 8;
    localparam int TH = 16;
    localparam int RW = BW * RP;
    localparam int OP = RP - 2;
    localparam int OW = BW * OP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sof;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] pix_in;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] pix_out;
    logic          out_last;

    median_denoise_pipe #(.BIT_WIDTH(BW), .ROW_PIX(RP), .ROWS(NR), .THRESH(TH)) dut (
        .clk(clk), .rst_n(rst_n), .sof(sof), .in_valid(in_valid), .in_ready(in_ready),
        .pix_in(pix_in), .out_valid(out_valid), .out_ready(out_ready),
        .pix_out(pix_out), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] pix;
        logic          last;
    } exp_t;

    int            n_chk = 0;
    int            n_fail = 0;
    int            n_del = 0;
    int            n_last = 0;
    exp_t          exp_q [$];
    logic [RW-1:0] frame_q [$];
    logic [OW-1:0] out_log [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Median as the value with at most 4 strictly smaller and at least 5 not larger.
    function automatic logic [7:0] med9(input logic [7:0] v [9]);
        int lt;
        int le;
        for (int i = 0; i < 9; i++) begin
            lt = 0;
            le = 0;
            for (int k = 0; k < 9; k++) begin
                if (v[k] < v[i]) lt++;
                if (v[k] <= v[i]) le++;
            end
            if (lt <= 4 && le >= 5) return v[i];
        end
        return 8'h00;
    endfunction

    function automatic logic [OW-1:0] model_row(input logic [RW-1:0] a, input logic [RW-1:0] b,
                                                input logic [RW-1:0] c);
        logic [OW-1:0] res;
        logic [7:0]    w [9];
        logic [7:0]    m;
        logic [7:0]    ctr;
        int            d;
        res = '0;
        for (int j = 0; j < OP; j++) begin
            for (int k = 0; k < 3; k++) begin
                w[k]     = a[(j+k)*BW +: BW];
                w[3 + k] = b[(j+k)*BW +: BW];
                w[6 + k] = c[(j+k)*BW +: BW];
            end
            m   = med9(w);
            ctr = b[(j+1)*BW +: BW];
`ifdef MEDIAN_DENOISE_THRESH_EN
            d = (int'(ctr) > int'(m)) ? int'(ctr) - int'(m) : int'(m) - int'(ctr);
            res[j*BW +: BW] = (d > TH) ? m : ctr;
`else
            d = 0;
            res[j*BW +: BW] = m;
`endif
        end
        return res;
    endfunction

    function automatic logic [RW-1:0] flat(input logic [7:0] v);
        logic [RW-1:0] r;
        for (int i = 0; i < RP; i++) r[i*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic [RW-1:0] mkrow(input int seed);
        logic [RW-1:0] r;
        for (int i = 0; i < RP; i++) r[i*BW +: BW] = 8'((seed * 29 + i * 71 + (seed ^ i) * 13) & 255);
        return r;
    endfunction

    // Compare process: handshake rule, stall stability, scoreboard, then model update.
    initial begin
        logic          stall_prev;
        logic [OW-1:0] hold_pix;
        logic          hold_last;
        exp_t          e;
        int            idx;
        stall_prev = 1'b0;
        hold_pix   = '0;
        hold_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                frame_q.delete();
                stall_prev = 1'b0;
            end else begin
                check("in_ready_rule", in_ready, !(out_valid && !out_ready));
                if (stall_prev) begin
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_pix", pix_out, hold_pix);
                    check("stall_last", out_last, hold_last);
                end
                if (out_valid && out_ready) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_out: got %0h expected none", pix_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("pix_out", pix_out, e.pix);
                        check("out_last", out_last, e.last);
                    end
                    out_log.push_back(pix_out);
                    n_del++;
                    if (out_last) n_last++;
                end
                stall_prev = out_valid && !out_ready;
                hold_pix   = pix_out;
                hold_last  = out_last;
                if (in_valid && in_ready) begin
                    if (sof) frame_q.delete();
                    idx = frame_q.size();
                    if (idx >= 2) begin
                        e.pix  = model_row(frame_q[idx-2], frame_q[idx-1], pix_in);
                        e.last = (idx == NR - 1);
                        exp_q.push_back(e);
                    end
                    frame_q.push_back(pix_in);
                    if (frame_q.size() == NR) frame_q.delete();
                end
            end
        end
    end

    task automatic send_row(input logic [RW-1:0] row, input logic s);
        int n;
        n        = 0;
        pix_in   = row;
        sof      = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int            d0;
        int            l0;
        int            n;
        logic [RW-1:0] row;
        logic [OW-1:0] tmp;

        rst_n = 1'b0; sof = 1'b0; in_valid = 1'b0; out_ready = 1'b1; pix_in = '0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_pix_out", pix_out, 48'h0);
        check("rst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Flat frame: six 0x40 outputs, latency two cycles, single out_last.
        d0 = n_del; l0 = n_last;
        for (int r = 0; r < NR; r++) begin
            if (r == 3) check("latency_before", out_valid, 1'b0);
            send_row(flat(8'h40), r == 0);
            if (r == 3) begin
                check("latency_at", out_valid, 1'b1);
                check("flat_first_pix", pix_out, 48'h404040404040);
            end
        end
        drain(4);
        check("flat_count", n_del - d0, 6);
        check("flat_last_count", n_last - l0, 1);

        // Impulse frame sent without sof: counter wrapped by itself.
        d0 = n_del;
        for (int r = 0; r < NR; r++) begin
            row = flat(8'h40);
            if (r == 3) row[4*BW +: BW] = 8'hFF;
            send_row(row, 1'b0);
        end
        drain(4);
        check("impulse_count", n_del - d0, 6);
        tmp = out_log[d0 + 2];
        check("impulse_removed", tmp[39:16], 24'h404040);

        // Small centre deviation kept only with the threshold feature.
        d0 = n_del;
        for (int r = 0; r < NR; r++) begin
            row = flat(8'h40);
            if (r == 1) begin
                row[1*BW +: BW] = 8'h48;
                row[4*BW +: BW] = 8'h60;
            end
            send_row(row, r == 0);
        end
        drain(4);
        tmp = out_log[d0];
`ifdef MEDIAN_DENOISE_THRESH_EN
        check("thresh_keep_center", tmp[7:0], 8'h48);
`else
        check("thresh_keep_center", tmp[7:0], 8'h40);
`endif
        check("thresh_replace_center", tmp[31:24], 8'h40);

        // Backpressure for five cycles in the middle of a frame.
        d0 = n_del; l0 = n_last;
        fork
            begin
                for (int r = 0; r < NR; r++) send_row(mkrow(r + 3), r == 0);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 200) begin
                    n++;
                    @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 1'b0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain(4);
        check("stall_count", n_del - d0, 6);
        check("stall_last_count", n_last - l0, 1);

        // sof arrives on row 4: old frame ends without out_last, new frame runs fully.
        d0 = n_del; l0 = n_last;
        for (int r = 0; r < 5; r++) send_row(mkrow(40 + r), (r == 0) || (r == 4));
        for (int r = 1; r < NR; r++) send_row(mkrow(60 + r), 1'b0);
        drain(4);
        check("sof_abort_count", n_del - d0, 8);
        check("sof_abort_last", n_last - l0, 1);

        // Reset after row 5 clears outputs immediately; restart at row 0 without sof.
        for (int r = 0; r < 6; r++) send_row(mkrow(80 + r), r == 0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_last", out_last, 1'b0);
        check("midrst_pix_out", pix_out, 48'h0);
        check("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        d0 = n_del;
        send_row(mkrow(90), 1'b0);
        send_row(mkrow(91), 1'b0);
        drain(2);
        check("midrst_no_early", n_del - d0, 0);
        send_row(mkrow(92), 1'b0);
        drain(4);
        check("midrst_count", n_del - d0, 1);

        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
